sha3_axis_absorb: RTL and testbench
===================================

// Module: sha3_axis_absorb
// PURPOSE
// AXI-Stream slave front end of the SHA3 core. Accepts 16-bit message beats, latches the SHA3 variant from TUSER and
// applies SHA3 multi-rate padding. Emits rate-sized blocks to the Keccak permutation over a valid/ready handshake.
// It is the receiving end of the message stream that the AXI_SHA bench and system masters drive.
// PARAMETERS
// DATA_WIDTH  16    beat width in bits; fixed at 16 for this revision (two bytes per beat)
// MAX_RATE    1152  widest rate in bits (SHA3-224); width of blk_data_o
// PORTS
// ACLK         in   1     clock
// ARESETn      in   1     asynchronous active-low reset
// TDATA_i      in   16    message beat; first byte in [15:8], second byte in [7:0]
// TKEEP_i      in   2     byte enables; [1] qualifies [15:8], [0] qualifies [7:0]
// TUSER_i      in   2     variant: 0=224, 1=256, 2=384, 3=512; sampled on the first beat only
// TVALID_i     in   1     beat valid
// TLAST_i      in   1     last beat of the message
// TREADY_o     out  1     beat accepted when TVALID_i&&TREADY_o
// blk_data_o   out  1152  block; word i at [1151-16*i -: 16]; words at and above blk_words_o are zero
// blk_words_o  out  7     rate in words: 72/68/52/36
// blk_mode_o   out  2     latched variant
// blk_last_o   out  1     final (padded) block of the message
// blk_valid_o  out  1     block valid; held with data stable until blk_ready_i
// blk_ready_i  in   1     permutation ready
// err_o        out  1     1-cycle pulse: non-last beat with TKEEP_i!=2'b11, or TKEEP_i==2'b01 (beat treated as 2'b11)
// BEHAVIOUR
// - Reset (async, ARESETn=0): state=IDLE, word count=0, block buffer=0; TREADY_o, blk_valid_o, blk_last_o, err_o=0;
//   blk_words_o=0, blk_mode_o=0. TREADY_o rises on the first ACLK edge after release.
// - States:
//   IDLE: TREADY_o=1; the first beat latches the mode, writes word 0 and goes to FILL.
//   FILL: TREADY_o=1; each beat writes the next word.
//   PAD: TREADY_o=0; applies padding in one cycle, then goes to OUT.
//   OUT: TREADY_o=0; blk_valid_o=1 until blk_ready_i.
// - Block full (count==rate words) on a non-TLAST beat: go to OUT next cycle, blk_last_o=0.
//   On handshake, clear the buffer and return to FILL.
// - TLAST beat with bytes left in the block: go to PAD.
//   Pad byte P (0x06) goes in the first free byte; 0x80 is ORed into the last rate byte (low byte of word rate-1).
//   If both fall on the same byte, that byte is 0x86. Then OUT with blk_last_o=1.
// - TLAST beat that fills the block exactly: OUT with blk_last_o=0, then PAD for an all-zero block
//   (word0=0x0600, word rate-1 = 0x0080), then OUT with blk_last_o=1.
// - TKEEP_i==2'b00 on a TLAST beat contributes no bytes; this covers the empty message.
// - After the blk_last_o handshake, clear everything and return to IDLE.
// - Latency: beat completing a block -> blk_valid_o next cycle. Last beat -> blk_valid_o two cycles later (via PAD).
// - TUSER_i changes mid-message are ignored. TLAST_i on the first beat in IDLE is legal.
// - blk_valid_o&&blk_ready_i in the same cycle as a new TVALID_i: the beat is not accepted that cycle
//   (TREADY_o=0 in OUT); it is accepted the cycle after.
// - ARESETn asserted mid-message or mid-OUT: the block is discarded, with no partial output.
// CONFIGURATION
// - SHA3_KECCAK_PAD_EN defined: P=0x01 (original Keccak padding); the coincident byte is 0x81.
// - SHA3_KECCAK_PAD_EN undefined: P=0x06 (FIPS 202 SHA3 domain); the coincident byte is 0x86.
// STRUCTURE
// - sha3_pkg: sha3_mode_t enum (SHA224..SHA512), function rate_words(mode) returning 72/68/52/36,
//   localparams PAD_SHA3=8'h06, PAD_KECCAK=8'h01, PAD_END=8'h80, MAX_RATE=1152.
// - Sub-module sha3_pad_inject (combinational): inputs = buffer, byte index, rate, P; output = padded buffer.
// - Top: FSM, word counter and buffer registers.
// TESTING
// - Empty SHA3-256 (one beat, TLAST=1, TKEEP=00) -> one block: word0=0x0600, word67=0x0080, other words 0,
//   blk_words_o=68, blk_last_o=1.
// - "abc" SHA3-256 (0x6162 keep 11; 0x6300 keep 10, TLAST) -> word0=0x6162, word1=0x6306, word67=0x0080, blk_last_o=1.
// - SHA3-512, 36 full beats with TLAST on the 36th -> block1 blk_last_o=0; block2 word0=0x0600, word35=0x0080,
//   blk_last_o=1.
// - SHA3-512, 35 full beats + 0xAB00 keep 10 TLAST -> single block: word35=0xAB86
//   (0xAB81 with SHA3_KECCAK_PAD_EN defined).
// - blk_ready_i held low 10 cycles in OUT -> TREADY_o=0 and blk_data_o stable throughout; no beat lost; err_o stays 0.
// - ARESETn pulsed low mid-message (SHA3-224, after 20 beats) -> outputs 0 immediately; the next message
//   yields a correct fresh block.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types, constants and helpers for the SHA3 AXI-Stream absorb front end.
// Contents:
//   sha3_mode_t   - SHA3 variant as carried on TUSER (224/256/384/512)
//   state_t       - absorb FSM state encoding
//   rate_words()  - rate of a variant in 16-bit words (72/68/52/36)
//   PAD_SHA3, PAD_KECCAK, PAD_END, MAX_RATE - padding bytes and widest rate
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'd0,
    SHA256 = 2'd1,
    SHA384 = 2'd2,
    SHA512 = 2'd3
  } sha3_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [7:0] PAD_SHA3   = 8'h06;
  localparam logic [7:0] PAD_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END    = 8'h80;
  localparam int         MAX_RATE   = 1152;

  function automatic logic [6:0] rate_words(sha3_mode_t mode);
    case (mode)
      SHA224:  rate_words = 7'd72;
      SHA256:  rate_words = 7'd68;
      SHA384:  rate_words = 7'd52;
      default: rate_words = 7'd36;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_inject.sv
// Combinational multi-rate padding of a rate block.
// Ports:
//   blk_i      - block buffer; byte b at [MAX_RATE-1-8*b -: 8]
//   byte_idx_i - index of the first free byte (receives the domain pad byte)
//   rate_i     - rate in 16-bit words; the last rate byte receives 0x80
//   pad_i      - domain pad byte (0x06 SHA3 or 0x01 Keccak)
//   blk_o      - padded block
// Free bytes are zero, so ORing both markers in place yields 0x86/0x81 when
// the first free byte is also the last rate byte.
module sha3_pad_inject (
  input  logic [sha3_pkg::MAX_RATE-1:0] blk_i,
  input  logic [7:0]                    byte_idx_i,
  input  logic [6:0]                    rate_i,
  input  logic [7:0]                    pad_i,
  output logic [sha3_pkg::MAX_RATE-1:0] blk_o
);
  import sha3_pkg::*;

  logic [7:0] last_b;

  assign last_b = {rate_i, 1'b0} - 8'd1;

  always_comb begin
    blk_o = blk_i;
    for (int b = 0; b < MAX_RATE / 8; b++) begin
      if (8'(b) == byte_idx_i)
        blk_o[MAX_RATE-1-8*b -: 8] = blk_o[MAX_RATE-1-8*b -: 8] | pad_i;
      if (8'(b) == last_b)
        blk_o[MAX_RATE-1-8*b -: 8] = blk_o[MAX_RATE-1-8*b -: 8] | PAD_END;
    end
  end

endmodule

// File: rtl/sha3_axis_absorb.sv
// AXI-Stream slave absorb front end of the SHA3 core.
// Collects 16-bit message beats into a rate-sized block, latches the variant
// from TUSER on the first beat, applies multi-rate padding and hands blocks to
// the Keccak permutation over a valid/ready handshake.
// Ports:
//   ACLK, ARESETn         - clock, asynchronous active-low reset
//   TDATA_i/TKEEP_i/TUSER_i/TVALID_i/TLAST_i/TREADY_o - AXI-Stream slave
//   blk_data_o            - block, word i at [MAX_RATE-1-16*i -: 16]
//   blk_words_o           - rate in words (0 while idle)
//   blk_mode_o            - latched variant
//   blk_last_o            - final padded block of the message
//   blk_valid_o/blk_ready_i - block handshake
//   err_o                 - one-cycle pulse after a beat with illegal TKEEP
// Build option: define SHA3_KECCAK_PAD_EN for original Keccak padding (0x01)
// instead of the FIPS 202 SHA3 domain byte (0x06).
module sha3_axis_absorb #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RATE   = 1152
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] TDATA_i,
  input  logic [1:0]            TKEEP_i,
  input  logic [1:0]            TUSER_i,
  input  logic                  TVALID_i,
  input  logic                  TLAST_i,
  output logic                  TREADY_o,
  output logic [MAX_RATE-1:0]   blk_data_o,
  output logic [6:0]            blk_words_o,
  output logic [1:0]            blk_mode_o,
  output logic                  blk_last_o,
  output logic                  blk_valid_o,
  input  logic                  blk_ready_i,
  output logic                  err_o
);
  import sha3_pkg::*;

`ifdef SHA3_KECCAK_PAD_EN
  localparam logic [7:0] PAD_P = PAD_KECCAK;
`else
  localparam logic [7:0] PAD_P = PAD_SHA3;
`endif

  state_t                state_q, state_d;
  logic                  armed_q;
  logic [6:0]            cnt_q, cnt_d;
  logic [MAX_RATE-1:0]   blk_q, blk_d;
  sha3_mode_t            mode_q, mode_d;
  logic                  last_q, last_d;
  logic                  fin_q, fin_d;     // exact fill on TLAST: an all-pad block follows
  logic [7:0]            pidx_q, pidx_d;
  logic                  err_q, err_d;

  logic                  fire;
  sha3_mode_t            cur_mode;
  logic [6:0]            rate;
  logic [1:0]            nb;
  logic                  bad_keep;
  logic                  full;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MAX_RATE-1:0]   pad_blk;

  sha3_pad_inject u_pad (
    .blk_i      (blk_q),
    .byte_idx_i (pidx_q),
    .rate_i     (rate),
    .pad_i      (PAD_P),
    .blk_o      (pad_blk)
  );

  // State register; armed_q holds TREADY low until the first edge after reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q  <= '0;
      blk_q  <= '0;
      mode_q <= SHA224;
      last_q <= 1'b0;
      fin_q  <= 1'b0;
      pidx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      mode_q <= mode_d;
      last_q <= last_d;
      fin_q  <= fin_d;
      pidx_q <= pidx_d;
      err_q  <= err_d;
    end
  end

  // Beat decode: byte count, write data and the illegal-keep flag.
  always_comb begin
    fire     = TVALID_i && TREADY_o;
    cur_mode = (state_q == ST_IDLE) ? sha3_mode_t'(TUSER_i) : mode_q;
    rate     = rate_words(cur_mode);
    nb       = 2'd2;
    if (TLAST_i) begin
      case (TKEEP_i)
        2'b10:   nb = 2'd1;
        2'b00:   nb = 2'd0;
        default: nb = 2'd2;
      endcase
    end
    bad_keep = TLAST_i ? (TKEEP_i == 2'b01) : (TKEEP_i != 2'b11);
    full     = (nb == 2'd2) && ((cnt_q + 7'd1) == rate);
    wdata    = (nb == 2'd1) ? {TDATA_i[DATA_WIDTH-1 -: 8], 8'h00} : TDATA_i;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    last_d  = last_q;
    fin_d   = fin_q;
    pidx_d  = pidx_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (fire) begin
          mode_d = cur_mode;
          err_d  = bad_keep;
          if (nb != 2'd0) begin
            cnt_d = cnt_q + 7'd1;
            for (int w = 0; w < MAX_RATE / 16; w++) begin
              if (7'(w) == cnt_q)
                blk_d[MAX_RATE-1-16*w -: 16] = wdata;
            end
          end
          if (TLAST_i) begin
            if (full) begin
              state_d = ST_OUT;
              fin_d   = 1'b1;
            end else begin
              state_d = ST_PAD;
              pidx_d  = {cnt_q, 1'b0} + {6'd0, nb};
            end
          end else begin
            state_d = full ? ST_OUT : ST_FILL;
          end
        end
      end
      ST_PAD: begin
        blk_d   = pad_blk;
        last_d  = 1'b1;
        state_d = ST_OUT;
      end
      default: begin
        if (blk_ready_i) begin
          blk_d  = '0;
          cnt_d  = '0;
          pidx_d = '0;
          if (last_q) begin
            state_d = ST_IDLE;
            last_d  = 1'b0;
            fin_d   = 1'b0;
            mode_d  = SHA224;
          end else if (fin_q) begin
            state_d = ST_PAD;
            fin_d   = 1'b0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    TREADY_o    = armed_q && ((state_q == ST_IDLE) || (state_q == ST_FILL));
    blk_valid_o = (state_q == ST_OUT);
    blk_words_o = (state_q == ST_IDLE) ? 7'd0 : rate_words(mode_q);
    blk_mode_o  = mode_q;
    blk_last_o  = last_q;
    blk_data_o  = blk_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_sha3_axis_absorb.sv
module tb_sha3_axis_absorb;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [15:0]   TDATA_i = '0;
  logic [1:0]    TKEEP_i = '0;
  logic [1:0]    TUSER_i = '0;
  logic          TVALID_i = 1'b0;
  logic          TLAST_i = 1'b0;
  logic          TREADY_o;
  logic [1151:0] blk_data_o;
  logic [6:0]    blk_words_o;
  logic [1:0]    blk_mode_o;
  logic          blk_last_o;
  logic          blk_valid_o;
  logic          blk_ready_i = 1'b0;
  logic          err_o;

  int            n_chk = 0;
  int            n_err = 0;
  logic          rdy_s = 1'b0;
  logic [1151:0] exp_blk;

`ifdef SHA3_KECCAK_PAD_EN
  localparam logic [15:0] W35_COINCIDE = 16'hAB81;
  localparam logic [15:0] PAD_W0      = 16'h0100;
  localparam logic [15:0] ABC_W1      = 16'h6301;
  localparam logic [15:0] ONE_BYTE_W0 = 16'hAB01;
`else
  localparam logic [15:0] W35_COINCIDE = 16'hAB86;
  localparam logic [15:0] PAD_W0      = 16'h0600;
  localparam logic [15:0] ABC_W1      = 16'h6306;
  localparam logic [15:0] ONE_BYTE_W0 = 16'hAB06;
`endif

  sha3_axis_absorb dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .TDATA_i     (TDATA_i),
    .TKEEP_i     (TKEEP_i),
    .TUSER_i     (TUSER_i),
    .TVALID_i    (TVALID_i),
    .TLAST_i     (TLAST_i),
    .TREADY_o    (TREADY_o),
    .blk_data_o  (blk_data_o),
    .blk_words_o (blk_words_o),
    .blk_mode_o  (blk_mode_o),
    .blk_last_o  (blk_last_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .err_o       (err_o)
  );

  always #5 ACLK = ~ACLK;

  // TREADY as seen in the half cycle before each rising edge.
  always @(negedge ACLK) rdy_s = TREADY_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag);
    n_chk++;
    assert (blk_data_o === exp_blk) else begin
      n_err++;
      $error("FAIL %s block differs: observed words0-3=%h expected words0-3=%h", tag,
             blk_data_o[1151 -: 64], exp_blk[1151 -: 64]);
    end
  endtask

  task automatic put(input int i, input logic [15:0] v);
    exp_blk[1151-16*i -: 16] = v;
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic beat(input logic [15:0] d, input logic [1:0] k, input logic [1:0] u, input logic l);
    bit ok;
    ok = 1'b0;
    TDATA_i  = d;
    TKEEP_i  = k;
    TUSER_i  = u;
    TLAST_i  = l;
    TVALID_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge ACLK);
      if (rdy_s) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    TVALID_i = 1'b0;
    TLAST_i  = 1'b0;
    if (!ok) begin
      n_chk++;
      n_err++;
      $error("FAIL beat_accept observed=timeout expected=accepted");
    end
  endtask

  // Return at a falling edge with blk_valid_o high, or report a timeout.
  task automatic wait_blk(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      if (blk_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      n_err++;
      $error("FAIL %s observed=no_blk_valid expected=blk_valid", tag);
    end
  endtask

  // Called at a falling edge while a block is valid.
  task automatic take_blk();
    blk_ready_i = 1'b1;
    @(posedge ACLK);
    #1;
    blk_ready_i = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_tready", TREADY_o, 0);
    chk("rst_valid", blk_valid_o, 0);
    chk("rst_last", blk_last_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_words", blk_words_o, 0);
    chk("rst_mode", blk_mode_o, 0);
    chk("rst_data_zero", (blk_data_o == '0), 1);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("tready_before_edge", TREADY_o, 0);
    @(negedge ACLK);
    chk("tready_after_edge", TREADY_o, 1);

    // Empty SHA3-256 message
    beat(16'h0000, 2'b00, 2'd1, 1'b1);
    @(negedge ACLK);
    chk("empty_pad_cycle_valid", blk_valid_o, 0);
    @(negedge ACLK);
    chk("empty_valid", blk_valid_o, 1);
    exp_blk = '0;
    put(0, PAD_W0);
    put(67, 16'h0080);
    chk_blk("empty_block");
    chk("empty_words", blk_words_o, 68);
    chk("empty_last", blk_last_o, 1);
    chk("empty_mode", blk_mode_o, 1);
    chk("empty_tready_out", TREADY_o, 0);
    take_blk();
    @(negedge ACLK);
    chk("empty_back_idle_words", blk_words_o, 0);
    chk("empty_back_idle_tready", TREADY_o, 1);

    // "abc" SHA3-256
    beat(16'h6162, 2'b11, 2'd1, 1'b0);
    beat(16'h6300, 2'b10, 2'd1, 1'b1);
    wait_blk("abc_wait");
    exp_blk = '0;
    put(0, 16'h6162);
    put(1, ABC_W1);
    put(67, 16'h0080);
    chk_blk("abc_block");
    chk("abc_last", blk_last_o, 1);
    chk("abc_err", err_o, 0);
    take_blk();

    // SHA3-512, 36 full beats, TLAST on the 36th: data block then all-pad block
    exp_blk = '0;
    for (int i = 0; i < 36; i++) begin
      beat(16'(16'hC000 + i), 2'b11, 2'd3, (i == 35));
      put(i, 16'(16'hC000 + i));
    end
    @(negedge ACLK);
    chk("full_latency_valid", blk_valid_o, 1);
    chk_blk("full_block1");
    chk("full_block1_last", blk_last_o, 0);
    chk("full_words", blk_words_o, 36);
    chk("full_mode", blk_mode_o, 3);
    take_blk();
    @(negedge ACLK);
    chk("full_pad_cycle_valid", blk_valid_o, 0);
    chk("full_pad_cycle_tready", TREADY_o, 0);
    @(negedge ACLK);
    chk("full_block2_valid", blk_valid_o, 1);
    exp_blk = '0;
    put(0, PAD_W0);
    put(35, 16'h0080);
    chk_blk("full_block2");
    chk("full_block2_last", blk_last_o, 1);
    take_blk();

    // SHA3-512, 35 full beats + one byte: pad byte coincides with the end marker
    exp_blk = '0;
    for (int i = 0; i < 35; i++) begin
      beat(16'(16'h5000 + 3 * i), 2'b11, 2'd3, 1'b0);
      put(i, 16'(16'h5000 + 3 * i));
    end
    beat(16'hAB00, 2'b10, 2'd3, 1'b1);
    put(35, W35_COINCIDE);
    wait_blk("coinc_wait");
    chk_blk("coinc_block");
    chk("coinc_last", blk_last_o, 1);

    // Back-pressure: ready low for 10 cycles, block and handshake held
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", blk_valid_o, 1);
      chk("bp_tready", TREADY_o, 0);
      chk("bp_err", err_o, 0);
      chk_blk("bp_stable");
      @(negedge ACLK);
    end
    // Next message's first beat arrives with the handshake; taken the cycle after
    chk("bp_tready_at_handshake", TREADY_o, 0);
    blk_ready_i = 1'b1;
    fork
      begin
        @(posedge ACLK);
        #1 blk_ready_i = 1'b0;
      end
    join_none
    beat(16'h0000, 2'b00, 2'd0, 1'b1);
    wait_blk("bp_next_wait");
    exp_blk = '0;
    put(0, PAD_W0);
    put(71, 16'h0080);
    chk_blk("bp_next_block");
    chk("bp_next_words", blk_words_o, 72);
    chk("bp_next_mode", blk_mode_o, 0);
    take_blk();

    // Illegal TKEEP on a non-last beat: err pulse, beat taken as full
    beat(16'h5A5A, 2'b10, 2'd1, 1'b0);
    @(negedge ACLK);
    chk("err_pulse", err_o, 1);
    beat(16'h1234, 2'b11, 2'd2, 1'b1);
    @(negedge ACLK);
    chk("err_cleared", err_o, 0);
    wait_blk("err_wait");
    exp_blk = '0;
    put(0, 16'h5A5A);
    put(1, 16'h1234);
    put(2, PAD_W0);
    put(67, 16'h0080);
    chk_blk("err_block");
    chk("err_mode_ignores_tuser", blk_mode_o, 1);
    take_blk();

    // Reset mid-message (SHA3-224 after 20 beats), then a fresh message
    for (int i = 0; i < 20; i++) beat(16'(16'h7700 + i), 2'b11, 2'd0, 1'b0);
    chk("mid_words_before_rst", blk_words_o, 72);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_tready", TREADY_o, 0);
    chk("mid_rst_valid", blk_valid_o, 0);
    chk("mid_rst_words", blk_words_o, 0);
    chk("mid_rst_data_zero", (blk_data_o == '0), 1);
    #2 ARESETn = 1'b1;
    beat(16'hAB00, 2'b10, 2'd0, 1'b1);
    wait_blk("fresh_wait");
    exp_blk = '0;
    put(0, ONE_BYTE_W0);
    put(71, 16'h0080);
    chk_blk("fresh_block");
    chk("fresh_last", blk_last_o, 1);
    take_blk();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
